// File: rtl/nibble_serial_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/nibble_serial_sub_if.sv
// Operand/result handshake bundle for nibble_serial_sub.
interface nibble_serial_sub_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] diff_o;
    logic             borrow_o;
    logic             overflow_o;
    logic             zero_o;

    // The subtractor side.
    modport slave (
        input  valid_i, a_i, b_i, ready_i,
        output ready_o, valid_o, diff_o, borrow_o, overflow_o, zero_o
    );

    // The producer/consumer side.
    modport master (
        output valid_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, diff_o, borrow_o, overflow_o, zero_o
    );
endinterface

// File: rtl/nibble_serial_sub_sub4_slice.sv
// Combinational 4-bit subtract slice: {carry_o, diff_o} = a + ~b + carry_i.
module sub4_slice
    import sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                carry_i,
    output logic [NIBBLE_W-1:0] diff_o,
    output logic                carry_o
);

    // Widen by one bit so the carry out of the nibble is captured.
    assign {carry_o, diff_o} = {1'b0, a} + {1'b0, ~b} + {{NIBBLE_W{1'b0}}, carry_i};

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle A - B, one nibble per clock, LSB nibble first, through a
// single shared sub4_slice. Result and flags are held until retired.
module nibble_serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    nibble_serial_sub_if.slave  bus
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    sub_state_t          state_q, state_d;
    logic [WIDTH-1:0]    a_q, b_q, res_q, res_full;
    logic                carry_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NIBBLE_W-1:0] a_nib, b_nib, d_nib;
    logic                c_out;
    logic                last_nib;
    logic [WIDTH-1:0]    diff_q;
    logic                borrow_q, overflow_q, zero_q;

    assign last_nib = (cnt_q == CNT_W'(N - 1));

    // Select the current operand nibbles by counter position.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        a_nib = a_q[int'(cnt_q) * NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[int'(cnt_q) * NIBBLE_W +: NIBBLE_W];
    end

    sub4_slice u_slice (
        .a       (a_nib),
        .b       (b_nib),
        .carry_i (carry_q),
        .diff_o  (d_nib),
        .carry_o (c_out)
    );

    // Result register with the nibble computed this cycle merged in.
    always_comb begin
        res_full = res_q;
        res_full[int'(cnt_q) * NIBBLE_W +: NIBBLE_W] = d_nib;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.valid_i) state_d = RUN;
            RUN:     if (last_nib)    state_d = DONE;
            DONE:    if (bus.ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Operand capture, nibble iteration and completion load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: every register here is reset, including the datapath, so outputs are defined after reset.
        if (rst_i) begin
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i) begin
                        a_q     <= bus.a_i;
                        b_q     <= bus.b_i;
                        carry_q <= 1'b1;   // two's complement: A + ~B + 1
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    res_q   <= res_full;
                    carry_q <= c_out;
                    if (last_nib) begin
                        cnt_q      <= '0;
                        diff_q     <= res_full;
                        borrow_q   <= ~c_out;
                        overflow_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                                      (res_full[WIDTH-1] ^ a_q[WIDTH-1]);
                        zero_q     <= (res_full == '0);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are pure state decodes; result outputs are registered.
    assign bus.ready_o    = (state_q == IDLE);
    assign bus.valid_o    = (state_q == DONE);
    assign bus.diff_o     = diff_q;
    assign bus.borrow_o   = borrow_q;
    assign bus.overflow_o = overflow_q;
    assign bus.zero_o     = zero_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed self-checking bench for nibble_serial_sub at WIDTH = 32.
module tb_nibble_serial_sub;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    nibble_serial_sub_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Accept one operation and wait for valid_o; leaves the DUT in DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        int w;
        w = 0;
        while (bus.ready_o !== 1'b1 && w < 30) begin
            @(posedge clk); #1; w++;
        end
        bus.valid_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        lat = 0;
        while (bus.valid_o !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 20) begin
            checks++; errors++;
            $display("FAIL timeout a=%h b=%h: valid_o never rose within 20 cycles", a, b);
        end
    endtask

    task automatic retire();
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.valid_o, bus.borrow_o, bus.overflow_o, bus.zero_o} !== 4'b0000 || bus.diff_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b b=%b o=%b z=%b d=%h, want all 0",
                     bus.valid_o, bus.borrow_o, bus.overflow_o, bus.zero_o, bus.diff_o);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", bus.ready_o);
        end
    endtask

    // Scenario 1 plus retirement behaviour.
    task automatic test_basic();
        int lat;
        run_op(32'h0000_0005, 32'h0000_0003, lat);
        checks++;
        if (lat !== 8) begin
            errors++; $display("FAIL latency: got %0d want 8", lat);
        end
        checks++;
        if ({bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o} !== {32'h0000_0002, 3'b000}) begin
            errors++; $display("FAIL basic_5m3: got d=%h b=%b o=%b z=%b want d=00000002 b=0 o=0 z=0",
                               bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o);
        end
        retire();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            errors++; $display("FAIL retire: got valid_o=%b ready_o=%b want 0/1", bus.valid_o, bus.ready_o);
        end
        checks++;
        if (bus.diff_o !== 32'h0000_0002) begin
            errors++; $display("FAIL hold_in_idle: got %h want 00000002", bus.diff_o);
        end
    endtask

    task automatic test_borrow();
        int lat;
        run_op(32'h0000_0003, 32'h0000_0005, lat);
        checks++;
        if ({bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o} !== {32'hFFFF_FFFE, 3'b100}) begin
            errors++; $display("FAIL borrow_3m5: got d=%h b=%b o=%b z=%b want d=fffffffe b=1 o=0 z=0",
                               bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o);
        end
        retire();
    endtask

    task automatic test_overflow();
        int lat;
        run_op(32'h8000_0000, 32'h0000_0001, lat);
        checks++;
        if ({bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o} !== {32'h7FFF_FFFF, 3'b010}) begin
            errors++; $display("FAIL ovf_neg: got d=%h b=%b o=%b z=%b want d=7fffffff b=0 o=1 z=0",
                               bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o);
        end
        retire();
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, lat);
        checks++;
        if ({bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o} !== {32'h8000_0000, 3'b110}) begin
            errors++; $display("FAIL ovf_pos: got d=%h b=%b o=%b z=%b want d=80000000 b=1 o=1 z=0",
                               bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o);
        end
        retire();
    endtask

    task automatic test_zero();
        int lat;
        run_op(32'h1234_5678, 32'h1234_5678, lat);
        checks++;
        if ({bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o} !== {32'h0, 3'b001}) begin
            errors++; $display("FAIL zero_eq: got d=%h b=%b o=%b z=%b want d=00000000 b=0 o=0 z=1",
                               bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o);
        end
        retire();
    endtask

    // Busy-time input noise and a consumer stall in DONE.
    task automatic test_hold();
        int lat;
        int w;
        w = 0;
        while (bus.ready_o !== 1'b1 && w < 30) begin
            @(posedge clk); #1; w++;
        end
        bus.valid_i = 1'b1; bus.a_i = 32'h0000_0100; bus.b_i = 32'h0000_0001;
        @(posedge clk); #1;
        lat = 0;
        // Keep valid_i high with scrambled operands through RUN.
        while (bus.valid_o !== 1'b1 && lat < 20) begin
            bus.a_i = 32'hDEAD_0000 + lat; bus.b_i = 32'h0BAD_F00D ^ lat;
            bus.valid_i = lat[0];
            checks++;
            if (bus.ready_o !== 1'b0) begin
                errors++; $display("FAIL ready_in_run: cycle %0d got %b want 0", lat, bus.ready_o);
            end
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 8) begin
            errors++; $display("FAIL hold_latency: got %0d want 8", lat);
        end
        for (int i = 0; i < 5; i++) begin
            bus.valid_i = 1'b1; bus.a_i = 32'h5555_5555 + i;
            checks++;
            if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 ||
                {bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o} !== {32'h0000_00FF, 3'b000}) begin
                errors++; $display("FAIL hold_done: cycle %0d got v=%b r=%b d=%h b=%b o=%b z=%b want v=1 r=0 d=000000ff flags 0",
                                   i, bus.valid_o, bus.ready_o, bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o);
            end
            @(posedge clk); #1;
        end
        bus.valid_i = 1'b0;
        retire();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.diff_o !== 32'h0000_00FF) begin
            errors++; $display("FAIL hold_retire: got v=%b r=%b d=%h want 0/1/000000ff",
                               bus.valid_o, bus.ready_o, bus.diff_o);
        end
    endtask

    // Asynchronous reset during RUN, then a normal operation.
    task automatic test_reset_mid();
        int lat;
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, lat);   // leaves borrow/overflow set
        retire();
        bus.valid_i = 1'b1; bus.a_i = 32'h0000_0003; bus.b_i = 32'h0000_0005;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.valid_o, bus.borrow_o, bus.overflow_o, bus.zero_o} !== 4'b0000 ||
            bus.diff_o !== 32'h0 || bus.ready_o !== 1'b1) begin
            errors++; $display("FAIL async_reset: got v=%b b=%b o=%b z=%b d=%h r=%b want 0 0 0 0 00000000 1",
                               bus.valid_o, bus.borrow_o, bus.overflow_o, bus.zero_o, bus.diff_o, bus.ready_o);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        run_op(32'h0000_0010, 32'h0000_0001, lat);
        checks++;
        if (lat !== 8 || {bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o} !== {32'h0000_000F, 3'b000}) begin
            errors++; $display("FAIL after_reset: got lat=%0d d=%h b=%b o=%b z=%b want 8 0000000f 0 0 0",
                               lat, bus.diff_o, bus.borrow_o, bus.overflow_o, bus.zero_o);
        end
        retire();
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_zero();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
